// File: rtl/ref_bank_sched_pkg.sv
// Shared constants and types for the ME_DMT reference-bank scheduler.
package me_dmt_pkg;
    localparam int PIXEL        = 8;
    localparam int PIX_PER_BEAT = 8;
    localparam int DW           = PIXEL * PIX_PER_BEAT;
    localparam int NUM_BANK     = 4;
    localparam int SEG_LEN      = 24;
    localparam int DEPTH        = 96;
    localparam int NUM_SEG      = NUM_BANK * DEPTH / SEG_LEN;
    localparam int AW           = $clog2(DEPTH);
    localparam int BW           = $clog2(NUM_BANK);
    localparam int SW           = $clog2(NUM_SEG);
    localparam int CW           = $clog2(SEG_LEN);

    typedef enum logic {
        RD_SEARCH = 1'b0,
        RD_REFINE = 1'b1
    } rd_port_t;

    function automatic logic [NUM_BANK-1:0] bank_onehot(input logic [BW-1:0] b);
        bank_onehot    = '0;
        bank_onehot[b] = 1'b1;
    endfunction
endpackage

// File: rtl/ref_bank_sched_if.sv
// Producer / consumer / read-requester side of the reference-bank scheduler.
interface ref_bank_sched_if;
    import me_dmt_pkg::*;

    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [1:0]    rd_req;
    logic [BW-1:0] rd_bank0;
    logic [BW-1:0] rd_bank1;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [1:0]    rd_gnt;
    logic [1:0]    rd_vld;
    logic          seg_release;
    logic [SW:0]   seg_cnt;
    logic          full;
    logic          empty;

    modport master (
        output wr_valid, wr_data, rd_req, rd_bank0, rd_bank1, rd_addr0, rd_addr1, seg_release,
        input  wr_ready, rd_gnt, rd_vld, seg_cnt, full, empty
    );

    modport slave (
        input  wr_valid, wr_data, rd_req, rd_bank0, rd_bank1, rd_addr0, rd_addr1, seg_release,
        output wr_ready, rd_gnt, rd_vld, seg_cnt, full, empty
    );
endinterface

// File: rtl/ref_bank_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-granted loses the next tie.
module rr_arb2
    import me_dmt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    rd_port_t r_prio;

    always_comb begin
        o_gnt = '0;
        if (i_req[RD_SEARCH] && (!i_req[RD_REFINE] || r_prio == RD_SEARCH))
            o_gnt[RD_SEARCH] = 1'b1;
        else if (i_req[RD_REFINE])
            o_gnt[RD_REFINE] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_prio <= RD_SEARCH;
        else if (o_gnt[RD_SEARCH])
            r_prio <= RD_REFINE;
        else if (o_gnt[RD_REFINE])
            r_prio <= RD_SEARCH;
    end
endmodule

// File: rtl/ref_bank_sched.sv
// Reference-bank write sequencer, live-segment tracker and shared read-path arbiter.
module ref_bank_sched
    import me_dmt_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    ref_bank_sched_if.slave     bus,
    output logic                bank_beg_en,
    output logic [NUM_BANK-1:0] bank_sel,
    output logic [DW-1:0]       bank_wdata,
    output logic [AW-1:0]       bank_addr,
    output logic [NUM_BANK-1:0] bank_rd_en
);
    localparam logic [CW-1:0] BEAT_LAST = CW'(SEG_LEN - 1);
    localparam logic [SW:0]   SEG_FULL  = (SW+1)'(NUM_SEG);

    logic [NUM_SEG-1:0]  r_live;
    logic [SW-1:0]       r_wr_seg;
    logic [SW-1:0]       r_rel_seg;
    logic [CW-1:0]       r_beat_cnt;
    logic [SW:0]         r_seg_cnt;
    logic                r_full;
    logic                r_empty;
    logic                r_beg_en_p1;
    logic [NUM_BANK-1:0] r_sel_p1;
    logic [DW-1:0]       r_wdata_p1;
    logic [AW-1:0]       r_addr_p1;
    logic [NUM_BANK-1:0] r_rd_en_p1;
    logic [1:0]          r_vld_p1;
    logic [1:0]          r_vld_p2;

    logic                w_wr_ready;
    logic                w_accept;
    logic                w_seg_done;
    logic                w_rel;
    logic [SW:0]         w_seg_cnt_nxt;
    logic [1:0]          w_gnt;

    // Segments fill in ring order, so the slot under the write pointer is live only when full.
    assign w_wr_ready = ~r_live[r_wr_seg];
    assign w_accept   = bus.wr_valid & w_wr_ready;
    assign w_seg_done = w_accept && (r_beat_cnt == BEAT_LAST);
    assign w_rel      = bus.seg_release & r_live[r_rel_seg];

    always_comb begin
        w_seg_cnt_nxt = r_seg_cnt;
        if (w_seg_done && !w_rel)
            w_seg_cnt_nxt = r_seg_cnt + 1'b1;
        else if (!w_seg_done && w_rel)
            w_seg_cnt_nxt = r_seg_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_live     <= '0;
            r_wr_seg   <= '0;
            r_rel_seg  <= '0;
            r_beat_cnt <= '0;
            r_seg_cnt  <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            if (w_accept)
                r_beat_cnt <= w_seg_done ? '0 : r_beat_cnt + 1'b1;
            if (w_seg_done) begin
                r_live[r_wr_seg] <= 1'b1;
                r_wr_seg         <= r_wr_seg + 1'b1;
            end
            if (w_rel) begin
                r_live[r_rel_seg] <= 1'b0;
                r_rel_seg         <= r_rel_seg + 1'b1;
            end
            r_seg_cnt <= w_seg_cnt_nxt;
            r_full    <= (w_seg_cnt_nxt == SEG_FULL);
            r_empty   <= (w_seg_cnt_nxt == '0);
        end
    end

    // Write stage p1: one registered strobe per accepted beat, bank = segment mod NUM_BANK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beg_en_p1 <= 1'b0;
            r_sel_p1    <= '0;
            r_wdata_p1  <= '0;
        end else begin
            r_beg_en_p1 <= w_accept;
            r_sel_p1    <= w_accept ? bank_onehot(r_wr_seg[BW-1:0]) : '0;
            if (w_accept)
                r_wdata_p1 <= bus.wr_data;
        end
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (bus.rd_req),
        .o_gnt (w_gnt)
    );

    // Read stage p1 drives the banks; p2 lines up with bank output data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr_p1  <= '0;
            r_rd_en_p1 <= '0;
            r_vld_p1   <= '0;
            r_vld_p2   <= '0;
        end else begin
            r_rd_en_p1 <= '0;
            if (w_gnt[RD_SEARCH]) begin
                r_addr_p1  <= bus.rd_addr0;
                r_rd_en_p1 <= bank_onehot(bus.rd_bank0);
            end else if (w_gnt[RD_REFINE]) begin
                r_addr_p1  <= bus.rd_addr1;
                r_rd_en_p1 <= bank_onehot(bus.rd_bank1);
            end
            r_vld_p1 <= w_gnt;
            r_vld_p2 <= r_vld_p1;
        end
    end

    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_gnt   = w_gnt;
    assign bus.rd_vld   = r_vld_p2;
    assign bus.seg_cnt  = r_seg_cnt;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bank_beg_en  = r_beg_en_p1;
    assign bank_sel     = r_sel_p1;
    assign bank_wdata   = r_wdata_p1;
    assign bank_addr    = r_addr_p1;
    assign bank_rd_en   = r_rd_en_p1;
endmodule

// File: tb/tb_ref_bank_sched.sv
// Directed + randomized bench for ref_bank_sched against a segment-count reference model.
module tb_ref_bank_sched;
    import me_dmt_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ref_bank_sched_if bus ();

    logic                bank_beg_en;
    logic [NUM_BANK-1:0] bank_sel;
    logic [DW-1:0]       bank_wdata;
    logic [AW-1:0]       bank_addr;
    logic [NUM_BANK-1:0] bank_rd_en;

    ref_bank_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .bank_beg_en (bank_beg_en),
        .bank_sel    (bank_sel),
        .bank_wdata  (bank_wdata),
        .bank_addr   (bank_addr),
        .bank_rd_en  (bank_rd_en)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: beats accepted and segments released since reset.
    int          m_written;
    int          m_rel;
    int          m_last;
    logic        m_beg;
    logic [3:0]  m_sel;
    logic [63:0] m_wdata;
    logic [6:0]  m_addr;
    logic [3:0]  m_rden;
    logic [1:0]  m_vld_p1;
    logic [1:0]  m_vld;

    function automatic int live_cnt();
        return m_written / SEG_LEN - m_rel;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        int lc;
        lc = live_cnt();
        chk("bank_beg_en", 64'(bank_beg_en), 64'(m_beg));
        chk("bank_sel",    64'(bank_sel),    64'(m_sel));
        chk("bank_wdata",  bank_wdata,       m_wdata);
        chk("bank_addr",   64'(bank_addr),   64'(m_addr));
        chk("bank_rd_en",  64'(bank_rd_en),  64'(m_rden));
        chk("rd_vld",      64'(bus.rd_vld),  64'(m_vld));
        chk("seg_cnt",     64'(bus.seg_cnt), 64'(lc));
        chk("full",        64'(bus.full),    64'(lc == NUM_SEG));
        chk("empty",       64'(bus.empty),   64'(lc == 0));
        chk("wr_ready_q",  64'(bus.wr_ready), 64'(lc != NUM_SEG));
    endtask

    task automatic model_reset();
        m_written = 0;
        m_rel     = 0;
        m_last    = 1;
        m_beg     = 1'b0;
        m_sel     = '0;
        m_wdata   = '0;
        m_addr    = '0;
        m_rden    = '0;
        m_vld_p1  = '0;
        m_vld     = '0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.seg_release = 1'b0;
        bus.rd_req      = '0;
        bus.rd_bank0    = '0;
        bus.rd_bank1    = '0;
        bus.rd_addr0    = '0;
        bus.rd_addr1    = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_regs();
        chk("rst_rd_gnt", 64'(bus.rd_gnt), 64'd0);
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic rel, input logic [1:0] req,
                        input logic [1:0] b0, input logic [6:0] a0,
                        input logic [1:0] b1, input logic [6:0] a1);
        logic       acc;
        logic       rel_ok;
        logic [1:0] g;
        int         lc;
        bus.wr_valid    = v;
        bus.wr_data     = d;
        bus.seg_release = rel;
        bus.rd_req      = req;
        bus.rd_bank0    = b0;
        bus.rd_addr0    = a0;
        bus.rd_bank1    = b1;
        bus.rd_addr1    = a1;
        #1;
        lc     = live_cnt();
        acc    = v && (lc != NUM_SEG);
        rel_ok = rel && (lc > 0);
        if (req == 2'b11) g = (m_last == 0) ? 2'b10 : 2'b01;
        else              g = req;
        chk("wr_ready", 64'(bus.wr_ready), 64'(lc != NUM_SEG));
        chk("rd_gnt",   64'(bus.rd_gnt),   64'(g));
        @(posedge clk);
        #1;
        m_beg = acc;
        m_sel = acc ? 4'(1 << ((m_written / SEG_LEN) % NUM_BANK)) : 4'b0;
        if (acc) m_wdata = d;
        if (acc) m_written++;
        if (rel_ok) m_rel++;
        m_vld    = m_vld_p1;
        m_vld_p1 = g;
        m_rden   = '0;
        if (g == 2'b01) begin
            m_addr = a0;
            m_rden = 4'(1 << b0);
            m_last = 0;
        end else if (g == 2'b10) begin
            m_addr = a1;
            m_rden = 4'(1 << b1);
            m_last = 1;
        end
        check_regs();
    endtask

    task automatic wr(input logic v, input logic [63:0] d, input logic rel);
        step(v, d, rel, 2'b00, 2'd0, 7'd0, 2'd0, 7'd0);
    endtask

    task automatic rnd_step();
        step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, ($urandom_range(0, 11) == 0),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 95)),
             2'($urandom_range(0, 3)), 7'($urandom_range(0, 95)));
    endtask

    initial begin
        model_reset();
        do_reset();

        // First segment: data 0..23 into bank0.
        for (int i = 0; i < 24; i++) wr(1'b1, 64'(i), 1'b0);
        chk("seg_cnt_first", 64'(bus.seg_cnt), 64'd1);

        // Fill all 16 segments, then keep offering beats while full.
        for (int i = 24; i < 384; i++) wr(1'b1, 64'(i), 1'b0);
        chk("full_after_384", 64'(bus.full), 64'd1);
        chk("seg_cnt_16", 64'(bus.seg_cnt), 64'd16);
        for (int i = 0; i < 4; i++) wr(1'b1, 64'hDEAD, 1'b0);

        // One release reopens the bank0 slot.
        wr(1'b0, 64'd0, 1'b1);
        chk("seg_cnt_15", 64'(bus.seg_cnt), 64'd15);
        chk("ready_after_rel", 64'(bus.wr_ready), 64'd1);
        for (int i = 0; i < 24; i++) wr(1'b1, {$urandom, $urandom}, 1'b0);

        // Drain past empty; extra releases are ignored.
        for (int i = 0; i < 20; i++) wr(1'b0, 64'd0, 1'b1);
        chk("seg_cnt_empty", 64'(bus.seg_cnt), 64'd0);
        chk("empty_flag", 64'(bus.empty), 64'd1);

        for (int i = 0; i < 500; i++) rnd_step();

        // Both requesters contend for six cycles from a fresh priority state.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b0, 2'b11, 2'd2, 7'd5, 2'd3, 7'd40);
        for (int i = 0; i < 2; i++) wr(1'b0, 64'd0, 1'b0);

        // Completion of beat 23 coincides with a release.
        for (int i = 0; i < 24; i++) wr(1'b1, 64'(100 + i), 1'b0);
        for (int i = 0; i < 23; i++) wr(1'b1, 64'(200 + i), 1'b0);
        wr(1'b1, 64'd223, 1'b1);
        chk("seg_cnt_coincide", 64'(bus.seg_cnt), 64'd1);
        for (int i = 0; i < 370; i++) wr(1'b1, 64'(300 + i), 1'b0);
        chk("full_after_coincide", 64'(bus.full), 64'd1);
        for (int i = 0; i < 30; i++) rnd_step();

        // Reset at beat 10 of a segment with reads in flight.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 64'(i), 1'b0, 2'b11, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 95)),
                 2'($urandom_range(0, 3)), 7'($urandom_range(0, 95)));
        do_reset();
        chk("rst_mid_vld", 64'(bus.rd_vld), 64'd0);
        wr(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        chk("post_rst_bank0", 64'(bank_sel), 64'b0001);
        for (int i = 0; i < 23; i++) wr(1'b1, 64'(i), 1'b0);
        chk("post_rst_seg", 64'(bus.seg_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
